// File: rtl/acq_pattern_gen.sv
// acq_pattern_gen
// ADC-domain sample pattern source. On start it latches a configuration,
// then emits one sample every div+1 cycles (ramp, constant, alternating or
// walking-one). A run ends after a programmed number of samples or on stop.
// One sample index per run can be flagged with trig_o. All outputs are
// registered.

module acq_pattern_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [1:0]            mode_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic [CNT_WIDTH-1:0]  num_samples_i,
    input  logic [CNT_WIDTH-1:0]  trig_pos_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  trig_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  smp_cnt_o
);

    localparam logic [1:0] MODE_RAMP  = 2'b00;
    localparam logic [1:0] MODE_CONST = 2'b01;
    localparam logic [1:0] MODE_ALT   = 2'b10;
    localparam logic [1:0] MODE_WALK  = 2'b11;

    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH-1:0]  DIV_ZERO  = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0]  DIV_ONE   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Configuration latched at start
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_seed;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [CNT_WIDTH-1:0]  r_num;
    logic [CNT_WIDTH-1:0]  r_trig_pos;

    // Run-time state
    logic [DIV_WIDTH-1:0]  r_div_cnt;
    logic [DATA_WIDTH-1:0] r_ramp;
    logic [DATA_WIDTH-1:0] r_walk;
    logic                  r_alt_odd;
    logic                  r_trig_fired;
    logic                  r_end;

    logic                  w_start;
    logic                  w_emit;
    logic                  w_last;
    logic                  w_stop;
    logic                  w_trig_hit;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic [DATA_WIDTH-1:0] w_pattern;

    assign w_cnt_inc  = smp_cnt_o + CNT_ONE;
    assign w_trig_hit = w_emit & ~r_trig_fired & (smp_cnt_o == r_trig_pos);

    // Control state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start/stop arbitration, emit decision, end of run
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_emit      = 1'b0;
        w_last      = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    w_state_nxt = ST_RUN;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    // stop beats a coincident emit
                    w_state_nxt = ST_IDLE;
                    w_stop      = 1'b1;
                end else if (r_div_cnt == r_div) begin
                    w_emit = 1'b1;
                    if ((r_num != CNT_ZERO) && (w_cnt_inc == r_num)) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pattern select for the sample about to be emitted
    always_comb begin
        w_pattern = r_seed;
        case (r_mode)
            MODE_RAMP:  w_pattern = r_ramp;
            MODE_CONST: w_pattern = r_seed;
            MODE_ALT: begin
                if (r_alt_odd) begin
                    w_pattern = ~r_seed;
                end else begin
                    w_pattern = r_seed;
                end
            end
            MODE_WALK:  w_pattern = r_walk;
            default:    w_pattern = r_seed;
        endcase
    end

    // Latch run configuration on the start edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mode     <= MODE_RAMP;
            r_seed     <= DATA_ZERO;
            r_div      <= DIV_ZERO;
            r_num      <= CNT_ZERO;
            r_trig_pos <= CNT_ZERO;
        end else if (w_start) begin
            r_mode     <= mode_i;
            r_seed     <= seed_i;
            r_div      <= div_i;
            r_num      <= num_samples_i;
            r_trig_pos <= trig_pos_i;
        end
    end

    // Rate divider and sample counter; counter holds after a run
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div_cnt <= DIV_ZERO;
            smp_cnt_o <= CNT_ZERO;
        end else if (w_start) begin
            r_div_cnt <= DIV_ZERO;
            smp_cnt_o <= CNT_ZERO;
        end else if (w_emit) begin
            r_div_cnt <= DIV_ZERO;
            smp_cnt_o <= w_cnt_inc;
        end else if ((r_state == ST_RUN) && !stop_i) begin
            r_div_cnt <= r_div_cnt + DIV_ONE;
        end
    end

    // Pattern generators advance on every emit; the ramp runs in its own
    // register so it keeps counting when the sample counter wraps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ramp    <= DATA_ZERO;
            r_walk    <= DATA_ONE;
            r_alt_odd <= 1'b0;
        end else if (w_start) begin
            r_ramp    <= seed_i;
            r_walk    <= DATA_ONE;
            r_alt_odd <= 1'b0;
        end else if (w_emit) begin
            r_ramp    <= r_ramp + DATA_ONE;
            r_walk    <= {r_walk[DATA_WIDTH-2:0], r_walk[DATA_WIDTH-1]};
            r_alt_odd <= ~r_alt_odd;
        end
    end

    // Trigger fires once per run, never again after a counter wrap
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_trig_fired <= 1'b0;
        end else if (w_start) begin
            r_trig_fired <= 1'b0;
        end else if (w_trig_hit) begin
            r_trig_fired <= 1'b1;
        end
    end

    // Registered outputs; done is delayed one cycle behind the ending edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= DATA_ZERO;
            valid_o <= 1'b0;
            trig_o  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            r_end   <= 1'b0;
        end else begin
            valid_o <= w_emit;
            trig_o  <= w_trig_hit;
            busy_o  <= (r_state == ST_RUN);
            r_end   <= w_last | w_stop;
            done_o  <= r_end;
            if (w_emit) begin
                data_o <= w_pattern;
            end
        end
    end

endmodule

// File: tb/tb_acq_pattern_gen.sv
// Directed testbench for acq_pattern_gen: each run is captured cycle by
// cycle and compared against hand-computed sample values and positions.

module tb_acq_pattern_gen;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        stop_i;
    logic [1:0]  mode_i;
    logic [63:0] seed_i;
    logic [15:0] div_i;
    logic [31:0] num_samples_i;
    logic [31:0] trig_pos_i;
    logic [63:0] data_o;
    logic        valid_o;
    logic        trig_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] smp_cnt_o;

    int n_pass  = 0;
    int n_total = 0;

    // capture results
    logic [63:0] cap_data [0:127];
    int          cap_cyc  [0:127];
    int          cap_n;
    int          trig_n;
    int          trig_cyc;
    logic [63:0] trig_data;
    int          done_n;
    int          done_cyc;
    logic        busy_at_done;
    int          busy_n;
    logic        busy_c0;
    logic        busy_c1;
    logic [31:0] cnt_c0;

    acq_pattern_gen #(
        .DATA_WIDTH(64),
        .CNT_WIDTH (32),
        .DIV_WIDTH (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .mode_i       (mode_i),
        .seed_i       (seed_i),
        .div_i        (div_i),
        .num_samples_i(num_samples_i),
        .trig_pos_i   (trig_pos_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .trig_o       (trig_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .smp_cnt_o    (smp_cnt_o)
    );

    // 100 MHz clock
    always #5 clk_i = ~clk_i;

    // Single comparison point
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] m, input logic [63:0] s, input logic [15:0] d,
                       input logic [31:0] n, input logic [31:0] t);
        mode_i        = m;
        seed_i        = s;
        div_i         = d;
        num_samples_i = n;
        trig_pos_i    = t;
    endtask

    // Observe ncyc cycles; cycle c is sampled at the falling edge after
    // start edge N+c. stop_c / xs_c inject stop / start sampled at edge N+c.
    task automatic capture(input int ncyc, input int stop_c, input int xs_c);
        cap_n        = 0;
        trig_n       = 0;
        trig_cyc     = -1;
        trig_data    = 64'h0;
        done_n       = 0;
        done_cyc     = -1;
        busy_at_done = 1'b1;
        busy_n       = 0;
        busy_c0      = 1'b0;
        busy_c1      = 1'b0;
        cnt_c0       = 32'h0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk_i);
            if (c == 0) begin
                busy_c0 = busy_o;
                cnt_c0  = smp_cnt_o;
            end
            if (c == 1) busy_c1 = busy_o;
            if (valid_o) begin
                if (cap_n < 128) begin
                    cap_data[cap_n] = data_o;
                    cap_cyc[cap_n]  = c;
                end
                cap_n++;
            end
            if (trig_o) begin
                if (trig_n == 0) begin
                    trig_cyc  = c;
                    trig_data = data_o;
                end
                trig_n++;
            end
            if (done_o) begin
                if (done_n == 0) begin
                    done_cyc     = c;
                    busy_at_done = busy_o;
                end
                done_n++;
            end
            if (busy_o) busy_n++;
            stop_i  = (c == stop_c - 1);
            start_i = (c == xs_c - 1);
        end
        stop_i  = 1'b0;
        start_i = 1'b0;
    endtask

    // Start pulse sampled at edge N, then scramble the config inputs to
    // show they were latched, then capture.
    task automatic run(input int ncyc, input int stop_c, input int xs_c);
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        seed_i        = ~seed_i;
        mode_i        = mode_i ^ 2'b01;
        div_i         = div_i + 16'd3;
        num_samples_i = num_samples_i + 32'd7;
        trig_pos_i    = trig_pos_i + 32'd1;
        capture(ncyc, stop_c, xs_c);
    endtask

    initial begin
        logic [63:0] alt_seed;
        logic [63:0] exp_w;
        rst_i   = 1'b1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        cfg(2'b00, 64'h0, 16'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_data",  data_o,            64'h0);
        chk("rst_valid", {63'h0, valid_o},  64'h0);
        chk("rst_trig",  {63'h0, trig_o},   64'h0);
        chk("rst_busy",  {63'h0, busy_o},   64'h0);
        chk("rst_done",  {63'h0, done_o},   64'h0);
        chk("rst_cnt",   {32'h0, smp_cnt_o}, 64'h0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // 1: ramp, div 0, 4 samples, trigger on index 2
        cfg(2'b00, 64'h10, 16'd0, 32'd4, 32'd2);
        run(10, -1, -1);
        chk("t1_busy_c0", {63'h0, busy_c0}, 64'h0);
        chk("t1_busy_c1", {63'h0, busy_c1}, 64'h1);
        chk("t1_n", 64'(cap_n), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_d%0d", k), cap_data[k], 64'h10 + 64'(k));
            chk($sformatf("t1_c%0d", k), 64'(cap_cyc[k]), 64'(1 + k));
        end
        chk("t1_trig_n", 64'(trig_n), 64'd1);
        chk("t1_trig_cyc", 64'(trig_cyc), 64'd3);
        chk("t1_trig_data", trig_data, 64'h12);
        chk("t1_done_n", 64'(done_n), 64'd1);
        chk("t1_done_cyc", 64'(done_cyc), 64'd5);
        chk("t1_busy_at_done", {63'h0, busy_at_done}, 64'h0);
        chk("t1_cnt", {32'h0, smp_cnt_o}, 64'd4);

        // 2: alternating, div 2, 3 samples, trigger on index 1
        alt_seed = 64'h00FF00FF00FF00FF;
        cfg(2'b10, alt_seed, 16'd2, 32'd3, 32'd1);
        run(14, -1, -1);
        chk("t2_n", 64'(cap_n), 64'd3);
        chk("t2_d0", cap_data[0], 64'h00FF00FF00FF00FF);
        chk("t2_d1", cap_data[1], 64'hFF00FF00FF00FF00);
        chk("t2_d2", cap_data[2], 64'h00FF00FF00FF00FF);
        chk("t2_c0", 64'(cap_cyc[0]), 64'd3);
        chk("t2_c1", 64'(cap_cyc[1]), 64'd6);
        chk("t2_c2", 64'(cap_cyc[2]), 64'd9);
        chk("t2_trig_cyc", 64'(trig_cyc), 64'd6);
        chk("t2_done_cyc", 64'(done_cyc), 64'd10);
        chk("t2_cnt", {32'h0, smp_cnt_o}, 64'd3);

        // 3a: ramp wrap from all-ones; trig_pos beyond num never fires
        cfg(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 16'd0, 32'd3, 32'd5);
        run(8, -1, -1);
        chk("t3a_n", 64'(cap_n), 64'd3);
        chk("t3a_d0", cap_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3a_d1", cap_data[1], 64'h0);
        chk("t3a_d2", cap_data[2], 64'h1);
        chk("t3a_trig_n", 64'(trig_n), 64'd0);
        chk("t3a_done_cyc", 64'(done_cyc), 64'd4);

        // 3b: walking one over 66 samples, seed ignored
        cfg(2'b11, 64'hDEAD_BEEF_0000_1234, 16'd0, 32'd66, 32'd65);
        run(72, -1, -1);
        chk("t3b_n", 64'(cap_n), 64'd66);
        for (int k = 0; k < 66; k++) begin
            exp_w = 64'h1 << (k % 64);
            chk($sformatf("t3b_d%0d", k), cap_data[k], exp_w);
        end
        chk("t3b_trig_cyc", 64'(trig_cyc), 64'd66);
        chk("t3b_trig_data", trig_data, 64'h2);
        chk("t3b_done_cyc", 64'(done_cyc), 64'd67);
        chk("t3b_cnt", {32'h0, smp_cnt_o}, 64'd66);

        // 4: continuous constant, div 1; stop on the 6th emit edge (c=12)
        cfg(2'b01, 64'hA5A5_5A5A_0F0F_F0F0, 16'd1, 32'd0, 32'd0);
        run(16, 12, -1);
        chk("t4_n", 64'(cap_n), 64'd5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t4_d%0d", k), cap_data[k], 64'hA5A5_5A5A_0F0F_F0F0);
            chk($sformatf("t4_c%0d", k), 64'(cap_cyc[k]), 64'(2 + 2 * k));
        end
        chk("t4_done_n", 64'(done_n), 64'd1);
        chk("t4_done_cyc", 64'(done_cyc), 64'd13);
        chk("t4_busy_at_done", {63'h0, busy_at_done}, 64'h0);
        chk("t4_cnt", {32'h0, smp_cnt_o}, 64'd5);
        chk("t4_hold_data", data_o, 64'hA5A5_5A5A_0F0F_F0F0);

        // 4b: restart clears the counter
        cfg(2'b01, 64'h1234, 16'd0, 32'd2, 32'd0);
        run(6, -1, -1);
        chk("t4b_cnt_c0", {32'h0, cnt_c0}, 64'd0);
        chk("t4b_n", 64'(cap_n), 64'd2);
        chk("t4b_d1", cap_data[1], 64'h1234);
        chk("t4b_cnt", {32'h0, smp_cnt_o}, 64'd2);

        // 5a: start and stop together in IDLE -> stays idle
        @(negedge clk_i);
        start_i = 1'b1;
        stop_i  = 1'b1;
        @(posedge clk_i);
        capture(5, -1, -1);
        chk("t5a_busy_n", 64'(busy_n), 64'd0);
        chk("t5a_valid_n", 64'(cap_n), 64'd0);
        chk("t5a_cnt", {32'h0, smp_cnt_o}, 64'd2);

        // 5b: start during RUN is ignored; trig_pos >= num never fires
        cfg(2'b00, 64'h100, 16'd1, 32'd4, 32'd10);
        run(12, -1, 3);
        chk("t5b_n", 64'(cap_n), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5b_d%0d", k), cap_data[k], 64'h100 + 64'(k));
            chk($sformatf("t5b_c%0d", k), 64'(cap_cyc[k]), 64'(2 + 2 * k));
        end
        chk("t5b_trig_n", 64'(trig_n), 64'd0);
        chk("t5b_done_cyc", 64'(done_cyc), 64'd9);
        chk("t5b_cnt", {32'h0, smp_cnt_o}, 64'd4);

        // 6: asynchronous reset mid-run
        cfg(2'b00, 64'h40, 16'd0, 32'd10, 32'd0);
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);          // c0
        start_i = 1'b0;
        @(negedge clk_i);          // c1
        @(negedge clk_i);          // c2: sample 1 on the output
        chk("t6_pre_valid", {63'h0, valid_o}, 64'h1);
        chk("t6_pre_data", data_o, 64'h41);
        #1;
        rst_i = 1'b1;
        #1;
        chk("t6_rst_data",  data_o,             64'h0);
        chk("t6_rst_valid", {63'h0, valid_o},   64'h0);
        chk("t6_rst_busy",  {63'h0, busy_o},    64'h0);
        chk("t6_rst_cnt",   {32'h0, smp_cnt_o}, 64'h0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        capture(4, -1, -1);
        chk("t6_no_done", 64'(done_n), 64'd0);
        chk("t6_idle", 64'(busy_n), 64'd0);
        cfg(2'b00, 64'h40, 16'd0, 32'd3, 32'd0);
        run(7, -1, -1);
        chk("t6_n", 64'(cap_n), 64'd3);
        chk("t6_d0", cap_data[0], 64'h40);
        chk("t6_d2", cap_data[2], 64'h42);
        chk("t6_c0", 64'(cap_cyc[0]), 64'd1);
        chk("t6_cnt", {32'h0, smp_cnt_o}, 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
